// File: rtl/antilog_pkg.sv
// rtl/antilog_pkg.sv - shared helpers and stage payload type for the antilog converter
package antilog_pkg;

    localparam int DEF_IN_B   = 16;
    localparam int DEF_LUT_B  = 9;
    localparam int DEF_FRAC_B = 3;
    localparam int DEF_N_CH   = 4;

    function automatic int ch_bits(input int n);
        int b;
        b = $clog2(n);
        return (b < 1) ? 1 : b;
    endfunction

    localparam int DEF_CH_B = ch_bits(DEF_N_CH);
    localparam int DEF_E_B  = DEF_IN_B - DEF_LUT_B - DEF_FRAC_B;

    // Elaboration-time only: real-valued 2^(k/2^lut_b), rounded to nearest by the int cast.
    function automatic int lut_value(input int k, input int lut_b, input int mant_b);
        real x;
        if (k >= (1 << lut_b)) begin
            return 1 << (mant_b + 1);
        end
        x = (2.0 ** mant_b) * (2.0 ** (real'(k) / real'(1 << lut_b)));
        return int'(x);
    endfunction

    typedef struct packed {
        logic [DEF_CH_B-1:0] ch;
        logic [DEF_E_B-1:0]  e;
    } stage_t;

endpackage

// File: rtl/antilog_lut.sv
// rtl/antilog_lut.sv - registered mantissa ROM; second read port only with ANTILOG_INTERP_EN
module antilog_lut
    import antilog_pkg::*;
#(
    parameter int LUT_B  = 9,
    parameter int MANT_B = 11,
    localparam int LW    = MANT_B + 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rd_en_i,
    input  logic [LUT_B-1:0] k0_i,
    output logic [LW-1:0]    l0_o
`ifdef ANTILOG_INTERP_EN
    ,
    input  logic [LUT_B:0]   k1_i,
    output logic [LW-1:0]    l1_o
`endif
);

`ifdef ANTILOG_INTERP_EN
    localparam int N = (1 << LUT_B) + 1;
`else
    localparam int N = 1 << LUT_B;
`endif
    localparam int IW = $clog2(N);

    logic [LW-1:0] rom [N];
    logic [LW-1:0] l0_q;

    for (genvar i = 0; i < N; i++) begin : g_rom
        assign rom[i] = LW'(lut_value(i, LUT_B, MANT_B));
    end

`ifdef ANTILOG_INTERP_EN
    logic [LW-1:0] l1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l0_q <= '0;
            l1_q <= '0;
        end else if (rd_en_i) begin
            l0_q <= rom[IW'(k0_i)];
            l1_q <= rom[k1_i];
        end
    end

    assign l1_o = l1_q;
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l0_q <= '0;
        end else if (rd_en_i) begin
            l0_q <= rom[IW'(k0_i)];
        end
    end
`endif

    assign l0_o = l0_q;

endmodule

// File: rtl/antilog_mc.sv
// rtl/antilog_mc.sv - 3-stage multichannel log-code to linear converter; ANTILOG_INTERP_EN enables interpolation
module antilog_mc
    import antilog_pkg::*;
#(
    parameter int IN_B      = 16,
    parameter int OUT_B     = 12,
    parameter int LUT_B     = 9,
    parameter int FRAC_B    = 3,
    parameter int MANT_B    = 11,
    parameter int IN_OFFSET = 3100,
    parameter int N_CH      = 4,
    localparam int CH_B     = ch_bits(N_CH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IN_B-1:0]  in_data,
    input  logic [CH_B-1:0]  in_ch,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_B-1:0] out_data,
    output logic [CH_B-1:0]  out_ch,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int E_B = IN_B - LUT_B - FRAC_B;
    localparam int LW  = MANT_B + 2;
    localparam int SW  = LW + OUT_B;

    if (CH_B != DEF_CH_B || E_B != DEF_E_B) begin : g_cfg_check
        $error("antilog_mc: CH_B and octave width must match antilog_pkg::stage_t");
    end

    logic                   adv;
    logic [IN_B-1:0]        d;
    logic [IN_B-FRAC_B-1:0] dq;
    logic [LUT_B-1:0]       k;
    logic [LW-1:0]          l0;
    logic [LW-1:0]          m_d, m2_q;
    stage_t                 s1_d, s1_q, s2_q;
    logic                   v1_q, v2_q;
    logic [SW-1:0]          y;
    logic [OUT_B-1:0]       out_data_d, out_data_q;
    logic                   out_sat_d, out_sat_q, out_valid_q;
    logic [CH_B-1:0]        out_ch_q;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    assign d    = (in_data < IN_B'(IN_OFFSET)) ? '0 : in_data - IN_B'(IN_OFFSET);
    assign dq   = (IN_B-FRAC_B)'(d >> FRAC_B);
    assign k    = dq[LUT_B-1:0];
    assign s1_d = '{ch: in_ch, e: dq[IN_B-FRAC_B-1:LUT_B]};

`ifdef ANTILOG_INTERP_EN
    logic [LUT_B:0]       k1;
    logic [LW-1:0]        l1;
    logic [FRAC_B-1:0]    f1_q;
    logic [LW+FRAC_B-1:0] prod;

    assign k1   = {1'b0, k} + (LUT_B+1)'(1);
    // The table is monotonic, so the slope is never negative.
    assign prod = (LW+FRAC_B)'(l1 - l0) * (LW+FRAC_B)'(f1_q);
    assign m_d  = l0 + LW'(prod >> FRAC_B);

    antilog_lut #(.LUT_B(LUT_B), .MANT_B(MANT_B)) u_lut (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_en_i (adv),
        .k0_i    (k),
        .l0_o    (l0),
        .k1_i    (k1),
        .l1_o    (l1)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f1_q <= '0;
        end else if (adv) begin
            f1_q <= d[FRAC_B-1:0];
        end
    end
`else
    assign m_d = l0;

    antilog_lut #(.LUT_B(LUT_B), .MANT_B(MANT_B)) u_lut (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_en_i (adv),
        .k0_i    (k),
        .l0_o    (l0)
    );
`endif

    // Mantissa is at least 2^MANT_B, so any octave >= OUT_B already overflows.
    always_comb begin
        y          = (SW'(m2_q) << s2_q.e) >> MANT_B;
        out_sat_d  = (32'(s2_q.e) >= OUT_B) || (y[SW-1:OUT_B] != '0);
        out_data_d = out_sat_d ? '1 : y[OUT_B-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            m2_q        <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_sat_q   <= 1'b0;
        end else if (adv) begin
            v1_q        <= in_valid;
            s1_q        <= s1_d;
            v2_q        <= v1_q;
            s2_q        <= s1_q;
            m2_q        <= m_d;
            out_valid_q <= v2_q;
            out_data_q  <= out_data_d;
            out_ch_q    <= s2_q.ch;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_antilog_mc.sv
// tb/tb_antilog_mc.sv - self-checking bench for antilog_mc against an arithmetic reference model
module tb_antilog_mc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in_data;
    logic [1:0]  in_ch;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] out_data;
    logic [1:0]  out_ch;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    antilog_mc dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_ch     (in_ch),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

`ifdef ANTILOG_INTERP_EN
    localparam int EXP_48160 = 2049;
    localparam int EXP_52251 = 4095;
`else
    localparam int EXP_48160 = 2048;
    localparam int EXP_52251 = 4090;
`endif

    typedef struct {
        int data;
        int ch;
        int sat;
        int acc;
    } exp_t;

    exp_t sbq[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;
    bit   hold_prev = 1'b0;
    int   prev_data, prev_ch, prev_sat;

    function automatic int lval(input int k);
        real r;
        if (k == 512) return 4096;
        r = 2048.0 * (2.0 ** (real'(k) / 512.0));
        return int'($floor(r + 0.5));
    endfunction

    function automatic exp_t model(input int x, input int ch);
        exp_t   r;
        int     dd, e, k, m;
        longint y;
        dd = (x < 3100) ? 0 : x - 3100;
        e  = dd / 4096;
        k  = (dd / 8) % 512;
        m  = lval(k);
`ifdef ANTILOG_INTERP_EN
        begin
            int f;
            f = dd % 8;
            m = m + ((lval(k + 1) - m) * f) / 8;
        end
`endif
        y      = (longint'(m) * (longint'(1) << e)) / 2048;
        r.sat  = (y > 4095) ? 1 : 0;
        r.data = (y > 4095) ? 4095 : int'(y);
        r.ch   = ch;
        r.acc  = 0;
        return r;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit iv, input int idat, input int ich, input bit ordy,
                         input bit lat, input int exp_data, input int exp_sat, output bit acc);
        exp_t e;
        in_valid  = iv;
        in_data   = 16'(idat);
        in_ch     = 2'(ich);
        out_ready = ordy;
        #1;
        if (hold_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
            chk("hold_ch", out_ch, prev_ch);
            chk("hold_sat", out_sat, prev_sat);
        end
        chk("in_ready", in_ready, (!out_valid || ordy) ? 1 : 0);
        if (out_valid && ordy) begin
            if (sbq.size() == 0) begin
                chk("spurious_out_valid", out_valid, 0);
            end else begin
                e = sbq.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_ch", out_ch, e.ch);
                chk("out_sat", out_sat, e.sat);
                if (lat) chk("latency", cyc - e.acc, 3);
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            e = model(idat, ich);
            if (exp_data >= 0) begin
                e.data = exp_data;
                e.sat  = exp_sat;
            end
            e.acc = cyc;
            sbq.push_back(e);
        end
        hold_prev = out_valid && !ordy;
        prev_data = int'(out_data);
        prev_ch   = int'(out_ch);
        prev_sat  = int'(out_sat);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input bit lat);
        bit a;
        for (int i = 0; i < 40 && sbq.size() != 0; i++) begin
            cycle(1'b0, 0, 0, 1'b1, lat, -1, 0, a);
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    task automatic one(input int x, input int ch, input int ed, input int es);
        bit a;
        cycle(1'b1, x, ch, 1'b1, 1'b1, ed, es, a);
        chk("one_accept", a, 1);
        drain(1'b1);
    endtask

    initial begin
        bit a;
        int sent, blocked;
        int bp_data[8];

        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ch     = '0;
        out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        one(3100, 0, 1, 0);
        one(0, 0, 1, 0);
        one(48156, 1, 2048, 0);
        one(48160, 2, EXP_48160, 0);
        one(52251, 3, EXP_52251, 0);
        one(65535, 0, 4095, 1);

        for (int i = 0; i < 8; i++) bp_data[i] = int'($urandom_range(3100, 52251));
        sent    = 0;
        blocked = 0;
        for (int i = 0; i < 30; i++) begin
            if (sent < 8) begin
                cycle(1'b1, bp_data[sent], sent % 4, !(i >= 4 && i <= 9), 1'b0, -1, 0, a);
                if (a) sent++;
                else blocked++;
            end else begin
                cycle(1'b0, 0, 0, !(i >= 4 && i <= 9), 1'b0, -1, 0, a);
            end
        end
        chk("bp_all_sent", sent, 8);
        chk("bp_blocked_cycles", blocked, 6);
        drain(1'b0);

        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0), 1'b0, -1, 0, a);
        end
        drain(1'b0);

        cycle(1'b1, 48156, 1, 1'b1, 1'b0, -1, 0, a);
        cycle(1'b1, 52251, 2, 1'b1, 1'b0, -1, 0, a);
        cycle(1'b0, 0, 0, 1'b1, 1'b0, -1, 0, a);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("midrst_pre_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_ch", out_ch, 0);
        chk("midrst_out_sat", out_sat, 0);
        sbq.delete();
        hold_prev = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) cycle(1'b0, 0, 0, 1'b1, 1'b0, -1, 0, a);
        one(48156, 3, 2048, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/antilog_mc.md
ANTILOG_MC -- requirements
Module: antilog_mc

Interface
REQ-001 SHALL have parameter IN_B, default 16, input code width.
REQ-002 SHALL have parameter OUT_B, default 12, output width.
REQ-003 SHALL have parameter LUT_B, default 9, mantissa LUT index width (2^LUT_B entries per octave).
REQ-004 SHALL have parameter FRAC_B, default 3, interpolation fraction width.
REQ-005 SHALL have parameter MANT_B, default 11, LUT mantissa fractional width.
REQ-006 SHALL have parameter IN_OFFSET, default 3100, code subtracted before conversion.
REQ-007 SHALL have parameter N_CH, default 4, channel count; CH_B = max(1, clog2(N_CH)).
REQ-008 SHALL have ports: clk input 1 clock; reset_n input 1, asynchronous active-low reset.
REQ-009 SHALL have ports: in_data input IN_B code; in_ch input CH_B channel tag; in_valid input 1; in_ready output 1.
REQ-010 SHALL have ports: out_data output OUT_B result; out_ch output CH_B tag; out_sat output 1 saturation flag; out_valid output 1; out_ready input 1.

Function
REQ-011 SHALL compute d = in_data - IN_OFFSET, clamped to 0 when in_data < IN_OFFSET.
REQ-012 SHALL split d: e = d[IN_B-1:LUT_B+FRAC_B] (octave), k = d[LUT_B+FRAC_B-1:FRAC_B] (index), f = d[FRAC_B-1:0].
REQ-013 SHALL use L[k] = round(2^MANT_B * 2^(k/2^LUT_B)) for k in 0..2^LUT_B-1, and L[2^LUT_B] = 2^(MANT_B+1).
REQ-014 SHALL form mantissa m = L[k] + (((L[k+1]-L[k])*f) >> FRAC_B), truncating, unsigned.
REQ-015 SHALL output y = (m << e) >> MANT_B; if y > 2^OUT_B-1, out_data = 2^OUT_B-1 and out_sat = 1, else out_sat = 0.
REQ-016 SHALL transfer input when in_valid && in_ready, output when out_valid && out_ready.
REQ-017 SHALL be a 3-stage pipeline, per-stage valid bit, fixed latency 3 cycles without backpressure.
REQ-018 SHALL advance all stages when adv = !out_valid || out_ready; in_ready = adv (combinational).
REQ-019 SHALL hold out_data/out_ch/out_sat/out_valid stable while out_valid && !out_ready.
REQ-020 SHALL carry in_ch unchanged to out_ch; results in input order, no loss, no duplication.
REQ-021 SHALL sustain one result per cycle when out_ready held high.

Reset
REQ-022 SHALL, on reset_n low, clear all stage valid bits; out_valid = 0, out_data = 0, out_ch = 0, out_sat = 0 immediately (asynchronous).
REQ-023 SHALL drop in-flight samples on reset mid-operation; first acceptance possible the first clk edge after reset_n rises.

Configuration
REQ-024 SHALL, with macro ANTILOG_INTERP_EN defined, implement REQ-014 interpolation.
REQ-025 SHALL, without ANTILOG_INTERP_EN, use m = L[k] (f ignored, no multiplier, no L[k+1] read), latency still 3.

Structure
REQ-026 SHALL place the L[] generation function, CH_B computation function, and stage payload struct typedef in package antilog_pkg.
REQ-027 SHALL instantiate sub-module antilog_lut: registered ROM, two read ports (k, k+1), read enable tied to adv.

Verification (defaults, IN_OFFSET 3100)
REQ-028 SHALL check: in_data 3100 and 0, ch 0 -> out_data 1, out_sat 0, 3 cycles after accept.
REQ-029 SHALL check: in_data 48156 (e=11,k=0,f=0) -> 2048; in_data 48160 (f=4) -> 2049 with ANTILOG_INTERP_EN, 2048 without.
REQ-030 SHALL check: in_data 52251 (e=11,k=511,f=7) -> 4095 with ANTILOG_INTERP_EN, 4090 without; in_data 65535 -> 4095, out_sat 1.
REQ-031 SHALL check: 8 back-to-back samples, ch 0..3 cycling, out_ready low for cycles 4-9 -> in_ready low while stalled, outputs held stable, all 8 results in order with correct out_ch.
REQ-032 SHALL check: reset_n pulsed low with 2 samples in flight -> out_valid low immediately, no stale result after release, next sample correct at latency 3.
